rx_ipv4: RTL and testbench



---
 rtl/rx_ipv4.sv | 140 ++++++++++++++
 tb/tb_rx_ipv4.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ipv4.sv
// IPv4 receive header parser: validates and strips the IPv4 header, forwarding only UDP payload to the local IP.
// Optional build macro RX_IPV4_CSUM_EN enables header checksum checking.
module rx_ipv4 #(
  parameter int OCT = 8
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic [OCT*4-1:0] my_ip,
  input  logic             rx_data_v,
  input  logic [OCT-1:0]   rx_data,
  output logic [OCT*4-1:0] rx_src_ip,
  output logic             rx_ip_data_v,
  output logic [OCT-1:0]   rx_ip_data,
  output logic             rx_ip_drop
);

  localparam int CW = OCT*2;

  typedef enum logic [1:0] {HEADER, PAYLOAD, DISCARD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    tot_len;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    hdr_len;
  logic [CW-1:0]    tot_full;
  logic [3:0]       ihl;
  logic             mf;
  logic [4:0]       frag_hi;
  logic [OCT*4-1:0] src_hold;
  logic [OCT*3-1:0] dst_hold;
  logic             bad;
  logic             is_last;
  logic             csum_ok;

  assign hdr_len  = CW'({ihl, 2'b00});
  // Full total_length as seen while byte 3 is on the bus.
  assign tot_full = {tot_len[OCT-1:0], rx_data};
  assign is_last  = (cnt >= CW'(19)) && (cnt == hdr_len - CW'(1));

  always_comb begin
    bad = 1'b0;
    case (cnt)
      CW'(0):  bad = (rx_data[7:4] != 4'd4) || (rx_data[3:0] < 4'd5);
      CW'(3):  bad = tot_full < hdr_len;
      CW'(7):  bad = mf || ({frag_hi, rx_data} != 13'd0);
      CW'(9):  bad = rx_data != OCT'(17);
      CW'(19): bad = {dst_hold, rx_data} != my_ip;
      default: bad = 1'b0;
    endcase
  end

`ifdef RX_IPV4_CSUM_EN
  logic [19:0]    acc;
  logic [19:0]    csum_sum;
  logic [OCT-1:0] word_hi;
  logic [16:0]    fold1;
  logic [15:0]    fold2;

  // The last header byte always completes a word, so include it before folding.
  assign csum_sum = acc + 20'({word_hi, rx_data});
  assign fold1    = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign fold2    = fold1[15:0] + 16'(fold1[16]);
  assign csum_ok  = (fold2 == 16'hFFFF);

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      word_hi <= '0;
    end else if (!rx_data_v) begin
      acc <= '0;
    end else if (state == HEADER) begin
      if (cnt[0]) acc <= csum_sum;
      else        word_hi <= rx_data;
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state        <= HEADER;
      cnt          <= '0;
      tot_len      <= '0;
      remaining    <= '0;
      ihl          <= '0;
      mf           <= 1'b0;
      frag_hi      <= '0;
      src_hold     <= '0;
      dst_hold     <= '0;
      rx_src_ip    <= '0;
      rx_ip_data_v <= 1'b0;
      rx_ip_data   <= '0;
      rx_ip_drop   <= 1'b0;
    end else begin
      rx_ip_drop <= 1'b0;
      if (!rx_data_v) begin
        state        <= HEADER;
        cnt          <= '0;
        rx_ip_data_v <= 1'b0;
      end else begin
        case (state)
          HEADER: begin
            rx_ip_data_v <= 1'b0;
            cnt          <= cnt + CW'(1);
            if (cnt == CW'(0)) ihl <= rx_data[3:0];
            if (cnt == CW'(2) || cnt == CW'(3)) tot_len <= tot_full;
            if (cnt == CW'(6)) begin
              mf      <= rx_data[5];
              frag_hi <= rx_data[4:0];
            end
            if (cnt >= CW'(12) && cnt <= CW'(15)) src_hold <= {src_hold[OCT*3-1:0], rx_data};
            if (cnt >= CW'(16) && cnt <= CW'(18)) dst_hold <= {dst_hold[OCT*2-1:0], rx_data};
            if (bad || (is_last && !csum_ok)) begin
              state      <= DISCARD;
              rx_ip_drop <= 1'b1;
            end else if (is_last) begin
              rx_src_ip <= src_hold;
              remaining <= tot_len - hdr_len;
              state     <= (tot_len == hdr_len) ? DISCARD : PAYLOAD;
            end
          end
          PAYLOAD: begin
            rx_ip_data   <= rx_data;
            rx_ip_data_v <= 1'b1;
            remaining    <= remaining - CW'(1);
            if (remaining == CW'(1)) state <= DISCARD;
          end
          DISCARD: rx_ip_data_v <= 1'b0;
          default: begin
            state        <= HEADER;
            rx_ip_data_v <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_ipv4.sv
// Self-checking bench for rx_ipv4: directed frames plus randomized frames against a field-level reference model.
module tb_rx_ipv4;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] my_ip = 32'hC0A8000A;
  logic        rx_data_v = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] rx_src_ip;
  logic        rx_ip_data_v;
  logic [7:0]  rx_ip_data;
  logic        rx_ip_drop;

  rx_ipv4 #(.OCT(8)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .my_ip(my_ip), .rx_data_v(rx_data_v), .rx_data(rx_data),
    .rx_src_ip(rx_src_ip), .rx_ip_data_v(rx_ip_data_v), .rx_ip_data(rx_ip_data), .rx_ip_drop(rx_ip_drop)
  );

  always #5 RX_CLK = ~RX_CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  obs_pl[$];
  int          obs_idx[$];
  int          obs_drop;
  int          obs_drops;
  logic [7:0]  exp_pl[$];
  int          exp_idx[$];
  int          exp_drop;
  logic [31:0] exp_src = 32'h0;

  // Header with a correct checksum (plus delta), then payload bytes pbase+i, then random padding.
  task automatic build_frame(input logic [3:0] ver, input logic [3:0] ihl, input int tot,
                             input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] proto,
                             input logic [31:0] src, input logic [31:0] dst, input int delta,
                             input int plen, input int pad, input int pbase);
    logic [7:0] h[64];
    int hl, hb;
    int unsigned s, c;
    hl = int'(ihl) * 4;
    hb = (hl < 20) ? 20 : hl;
    h[0] = {ver, ihl};  h[1] = 8'h00;
    h[2] = 8'(tot >> 8); h[3] = 8'(tot);
    h[4] = 8'($urandom); h[5] = 8'($urandom);
    h[6] = b6; h[7] = b7; h[8] = 8'h40; h[9] = proto;
    h[10] = 8'h00; h[11] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      h[12+k] = 8'(src >> (24 - 8*k));
      h[16+k] = 8'(dst >> (24 - 8*k));
    end
    for (int k = 20; k < hb; k++) h[k] = 8'($urandom);
    s = 0;
    for (int k = 0; k < hb; k += 2) s += (int'(h[k]) << 8) + int'(h[k+1]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    c = ((~s) + delta) & 32'hFFFF;
    h[10] = 8'(c >> 8); h[11] = 8'(c);
    frame_q.delete();
    for (int k = 0; k < hb; k++) frame_q.push_back(h[k]);
    for (int k = 0; k < plen; k++) frame_q.push_back(8'(pbase + k));
    for (int k = 0; k < pad; k++) frame_q.push_back(8'($urandom));
  endtask

  task automatic build_basic(input logic [31:0] dst, input int delta);
    build_frame(4'd4, 4'd5, 36, 8'h00, 8'h00, 8'd17, 32'hC0A80001, dst, delta, 16, 0, 0);
  endtask

  // Drive frame_q then gap idle cycles; record each output against the input byte index that caused it.
  task automatic run_frame(input int gap);
    int n;
    n = frame_q.size();
    obs_pl.delete(); obs_idx.delete();
    obs_drop = -1; obs_drops = 0;
    for (int i = 0; i <= n + gap; i++) begin
      @(negedge RX_CLK);
      if (i > 0) begin
        if (rx_ip_data_v === 1'b1) begin
          obs_pl.push_back(rx_ip_data);
          obs_idx.push_back(i - 1);
        end
        if (rx_ip_drop === 1'b1) begin
          obs_drops++;
          if (obs_drop < 0) obs_drop = i - 1;
        end
      end
      if (i < n) begin rx_data_v = 1'b1; rx_data = frame_q[i]; end
      else       begin rx_data_v = 1'b0; rx_data = 8'h00; end
    end
  endtask

  // Reference model: decide the fate of frame_q from its header fields.
  task automatic model_frame();
    int L, ver, ihl, hl, tot, frag;
    int unsigned s, dst;
    exp_pl.delete(); exp_idx.delete();
    exp_drop = -1;
    L = frame_q.size();
    if (L < 1) return;
    ver = int'(frame_q[0]) >> 4;
    ihl = int'(frame_q[0]) & 15;
    hl  = ihl * 4;
    if (ver != 4 || ihl < 5) begin exp_drop = 0; return; end
    if (L < 4) return;
    tot = (int'(frame_q[2]) << 8) + int'(frame_q[3]);
    if (tot < hl) begin exp_drop = 3; return; end
    if (L < 8) return;
    frag = ((int'(frame_q[6]) & 31) << 8) + int'(frame_q[7]);
    if ((int'(frame_q[6]) & 32) != 0 || frag != 0) begin exp_drop = 7; return; end
    if (L < 10) return;
    if (frame_q[9] != 8'd17) begin exp_drop = 9; return; end
    if (L < 20) return;
    dst = {frame_q[16], frame_q[17], frame_q[18], frame_q[19]};
    if (dst != my_ip) begin exp_drop = 19; return; end
    if (L < hl) return;
    s = 0;
    for (int k = 0; k < hl; k += 2) s += (int'(frame_q[k]) << 8) + int'(frame_q[k+1]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`ifdef RX_IPV4_CSUM_EN
    if (s != 32'hFFFF) begin exp_drop = hl - 1; return; end
`endif
    exp_src = {frame_q[12], frame_q[13], frame_q[14], frame_q[15]};
    for (int k = hl; k < tot && k < L; k++) begin
      exp_pl.push_back(frame_q[k]);
      exp_idx.push_back(k);
    end
  endtask

  function automatic bit pl_ok();
    if (obs_pl.size() != exp_pl.size()) return 1'b0;
    foreach (obs_pl[k])
      if (obs_pl[k] !== exp_pl[k] || obs_idx[k] != exp_idx[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge RX_CLK); @(negedge RX_CLK);
    checks++; if (rx_ip_data_v !== 1'b0) begin errors++; $display("FAIL reset_data_v: got %b required 0", rx_ip_data_v); end
    checks++; if (rx_ip_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", rx_ip_data); end
    checks++; if (rx_src_ip !== 32'h0) begin errors++; $display("FAIL reset_src_ip: got %h required 00000000", rx_src_ip); end
    checks++; if (rx_ip_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b required 0", rx_ip_drop); end
    rst = 1'b1;
    @(negedge RX_CLK);
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    build_basic(32'hC0A8000A, 0);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok()) begin errors++; $display("FAIL basic_payload: got %0d bytes required %0d", obs_pl.size(), exp_pl.size()); end
    checks++; if (obs_pl.size() != 16 || obs_idx[0] != 20 || obs_pl[0] !== 8'h00 || obs_pl[15] !== 8'h0F) begin
      errors++; $display("FAIL basic_shape: got %0d bytes required 16 starting at byte 20 carrying 00..0F", obs_pl.size()); end
    checks++; if (obs_drops != 0) begin errors++; $display("FAIL basic_drop: got %0d pulses required 0", obs_drops); end
    checks++; if (rx_src_ip !== 32'hC0A80001) begin errors++; $display("FAIL basic_src_ip: got %h required c0a80001", rx_src_ip); end
    $display("basic: %0d payload bytes, src %h", obs_pl.size(), rx_src_ip);
  endtask

  task automatic test_dst_mismatch();
    build_basic(32'hC0A8000B, 0);
    run_frame(3);
    model_frame();
    checks++; if (obs_drop != 19 || obs_drops != 1) begin errors++; $display("FAIL dst_drop: got byte %0d (%0d pulses) required byte 19 (1 pulse)", obs_drop, obs_drops); end
    checks++; if (obs_pl.size() != 0) begin errors++; $display("FAIL dst_payload: got %0d bytes required 0", obs_pl.size()); end
    checks++; if (rx_src_ip !== exp_src) begin errors++; $display("FAIL dst_src_ip: got %h required %h", rx_src_ip, exp_src); end
    $display("dst_mismatch: drop at byte %0d", obs_drop);
  endtask

  task automatic test_bad_csum();
    build_basic(32'hC0A8000A, 1);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok()) begin errors++; $display("FAIL csum_payload: got %0d bytes required %0d", obs_pl.size(), exp_pl.size()); end
    checks++; if (obs_drop != exp_drop || obs_drops > 1) begin errors++; $display("FAIL csum_drop: got byte %0d required %0d", obs_drop, exp_drop); end
    $display("bad_csum: %0d payload bytes, drop byte %0d", obs_pl.size(), obs_drop);
  endtask

  task automatic test_options();
    build_frame(4'd4, 4'd6, 32, 8'h40, 8'h00, 8'd17, 32'h0A000002, 32'hC0A8000A, 0, 8, 0, 8'h30);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok()) begin errors++; $display("FAIL options_payload: got %0d bytes required %0d", obs_pl.size(), exp_pl.size()); end
    checks++; if (obs_pl.size() != 8 || obs_idx[0] != 24) begin errors++; $display("FAIL options_shape: got %0d bytes required 8 starting at byte 24", obs_pl.size()); end
    checks++; if (rx_src_ip !== 32'h0A000002) begin errors++; $display("FAIL options_src_ip: got %h required 0a000002", rx_src_ip); end
    $display("options: %0d payload bytes", obs_pl.size());
  endtask

  task automatic test_padding();
    build_frame(4'd4, 4'd5, 28, 8'h00, 8'h00, 8'd17, 32'hC0A80001, 32'hC0A8000A, 0, 8, 18, 8'h80);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok() || obs_pl.size() != 8) begin errors++; $display("FAIL padding_payload: got %0d bytes required 8", obs_pl.size()); end
    checks++; if (obs_drops != 0) begin errors++; $display("FAIL padding_drop: got %0d pulses required 0", obs_drops); end
    $display("padding: %0d payload bytes from %0d byte frame", obs_pl.size(), frame_q.size());
  endtask

  task automatic test_truncate();
    build_basic(32'hC0A8000A, 0);
    while (frame_q.size() > 10) void'(frame_q.pop_back());
    run_frame(2);
    model_frame();
    checks++; if (obs_pl.size() != 0 || obs_drops != 0) begin errors++; $display("FAIL truncate_silent: got %0d bytes %0d pulses required 0 and 0", obs_pl.size(), obs_drops); end
    build_basic(32'hC0A8000A, 0);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok() || obs_drops != 0) begin errors++; $display("FAIL truncate_next: got %0d bytes required %0d", obs_pl.size(), exp_pl.size()); end
    $display("truncate: following frame gave %0d payload bytes", obs_pl.size());
  endtask

  task automatic test_async_reset();
    build_basic(32'hC0A8000A, 0);
    for (int i = 0; i < 26; i++) begin
      @(negedge RX_CLK);
      rx_data_v = 1'b1; rx_data = frame_q[i];
    end
    checks++; if (rx_ip_data_v !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b required 1", rx_ip_data_v); end
    #2 rst = 1'b0;
    #1;
    exp_src = 32'h0;
    checks++; if (rx_ip_data_v !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b required 0", rx_ip_data_v); end
    checks++; if (rx_src_ip !== exp_src || rx_ip_drop !== 1'b0) begin errors++; $display("FAIL areset_state: got src %h drop %b required 00000000 0", rx_src_ip, rx_ip_drop); end
    @(negedge RX_CLK); rx_data_v = 1'b0; rx_data = 8'h00;
    @(negedge RX_CLK); rst = 1'b1;
    build_basic(32'hC0A8000A, 0);
    run_frame(3);
    model_frame();
    checks++; if (!pl_ok() || obs_drops != 0) begin errors++; $display("FAIL areset_next: got %0d bytes %0d pulses required %0d bytes", obs_pl.size(), obs_drops, exp_pl.size()); end
    checks++; if (rx_src_ip !== exp_src) begin errors++; $display("FAIL areset_src_ip: got %h required %h", rx_src_ip, exp_src); end
    $display("async_reset: next frame gave %0d payload bytes", obs_pl.size());
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int kind, ihl, plen, tot, pad, delta, len;
      logic [3:0] ver;
      logic [7:0] b6, b7, proto;
      logic [31:0] dst;
      kind = $urandom_range(0, 9);
      ver = 4'd4; ihl = $urandom_range(5, 8); plen = $urandom_range(0, 20);
      pad = $urandom_range(0, 6); delta = 0; proto = 8'd17; b7 = 8'h00; dst = my_ip;
      b6 = ($urandom_range(0, 1) == 1) ? 8'h40 : 8'h00;
      tot = ihl * 4 + plen;
      case (kind)
        1: ver = 4'($urandom_range(0, 15));
        2: ihl = $urandom_range(0, 4);
        3: tot = $urandom_range(0, ihl * 4 - 1);
        4: b6 = b6 | 8'h20;
        5: b7 = 8'($urandom_range(1, 255));
        6: proto = 8'($urandom_range(0, 255));
        7: dst = my_ip ^ (32'h1 << $urandom_range(0, 31));
        8: delta = $urandom_range(1, 100);
        default: ;
      endcase
      build_frame(ver, 4'(ihl), tot, b6, b7, proto, $urandom, dst, delta, plen, pad, $urandom_range(0, 255));
      if (kind == 9) begin
        len = $urandom_range(1, frame_q.size());
        while (frame_q.size() > len) void'(frame_q.pop_back());
      end
      run_frame($urandom_range(1, 3));
      model_frame();
      checks++; if (!pl_ok()) begin errors++; $display("FAIL rand%0d_payload: got %0d bytes required %0d", t, obs_pl.size(), exp_pl.size()); end
      checks++; if (obs_drop != exp_drop || obs_drops > 1) begin errors++; $display("FAIL rand%0d_drop: got byte %0d (%0d pulses) required byte %0d", t, obs_drop, obs_drops, exp_drop); end
      checks++; if (rx_src_ip !== exp_src) begin errors++; $display("FAIL rand%0d_src_ip: got %h required %h", t, rx_src_ip, exp_src); end
      $display("random %0d: kind %0d len %0d payload %0d drop %0d", t, kind, frame_q.size(), obs_pl.size(), obs_drop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dst_mismatch();
    test_bad_csum();
    test_options();
    test_padding();
    test_truncate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
